// File: rtl/tns_encoder_multi_if.sv
// Stream interface for tns_encoder_multi.
// Carries the input beat (symbols) and the output beat (codewords plus per-lane error flags).
// The master drives symbols and accepts codewords; the slave is the encoder.
interface tns_encoder_multi_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*DW-1:0]  datain;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*3-1:0]   codeout;
    logic [LANES-1:0]     lane_err;

    modport master (
        output in_valid,
        output datain,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  codeout,
        input  lane_err
    );

    modport slave (
        input  in_valid,
        input  datain,
        input  out_ready,
        output in_ready,
        output out_valid,
        output codeout,
        output lane_err
    );
endinterface

// File: rtl/tns_encoder_multi.sv
// Multi-lane TNS (transition-memory) crosstalk-avoidance encoder.
// Each lane maps a DW-bit symbol to a 3-bit codeword; the codeword MSB remembers its previous
// value while the symbol sits in the overlap band. Lane memory advances only on accepted beats.
// Optional feature: define TNS_MULTI_ERRCNT_EN to add the saturating err_cnt output.
module tns_encoder_multi #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 3,
    parameter int unsigned TNS_A = 3,
    parameter int unsigned TNS_B = 2,
    parameter int unsigned TNS_C = 1
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    sync_clr,
    tns_encoder_multi_if.slave      bus_io,
    output logic                    err_sticky
`ifdef TNS_MULTI_ERRCNT_EN
    ,
    output logic [15:0]             err_cnt
`endif
);

    // Reject threshold sets that cannot form a valid code at elaboration time.
    if ((TNS_A > TNS_B + 2) || (TNS_A + TNS_C > TNS_B + 2) ||
        ((1 << DW) <= TNS_A + TNS_B + 1)) begin : g_param_err
        $error("tns_encoder_multi: illegal TNS_A/TNS_B/TNS_C/DW combination");
    end

    localparam logic [DW:0] ThrA  = (DW+1)'(TNS_A);
    localparam logic [DW:0] ThrB  = (DW+1)'(TNS_B);
    localparam logic [DW:0] ThrAc = (DW+1)'(TNS_A + TNS_C);
    localparam logic [DW:0] MaxIn = (DW+1)'(TNS_A + TNS_B + 1);

    // Returns {err, c2, c1, c0}; out-of-range symbols give err=1 and codeword 000.
    function automatic logic [3:0] tns_encode(input logic [DW-1:0] sym, input logic r);
        logic [DW:0] d;
        logic [DW:0] rb;
        logic [DW:0] rc;
        logic        c2;
        logic        c1;
        d = {1'b0, sym};
        if (d > MaxIn) begin
            return 4'b1000;
        end
        if (d < ThrA) begin
            c2 = 1'b0;
        end else if (d >= ThrAc) begin
            c2 = 1'b1;
        end else begin
            c2 = r;
        end
        rb = c2 ? d - ThrA : d;
        c1 = (rb >= ThrB);
        rc = c1 ? rb - ThrB : rb;
        return {1'b0, c2, c1, rc[0]};
    endfunction

    logic                  out_valid_q, out_valid_d;
    logic [LANES*3-1:0]    codeout_q, codeout_d;
    logic [LANES-1:0]      lane_err_q, lane_err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [LANES-1:0]      r_q, r_d;
    logic [3:0]            enc_c [LANES];
    logic [LANES*3-1:0]    code_c;
    logic [LANES-1:0]      err_c;
    logic                  accept;
    logic                  any_err;

    assign bus_io.in_ready = ~out_valid_q | bus_io.out_ready;
    assign accept          = bus_io.in_valid & bus_io.in_ready;

    // Per-lane encode and next-state for lane memory, output register and sticky error.
    always_comb begin
        any_err = 1'b0;
        code_c  = '0;
        err_c   = '0;
        r_d     = r_q;
        for (int i = 0; i < LANES; i++) begin
            // sync_clr forces the effective memory to 0 for this cycle's beat.
            enc_c[i]       = tns_encode(bus_io.datain[i*DW +: DW], sync_clr ? 1'b0 : r_q[i]);
            code_c[i*3 +: 3] = enc_c[i][2:0];
            err_c[i]       = enc_c[i][3];
            any_err        = any_err | enc_c[i][3];
            if (accept && !enc_c[i][3]) begin
                r_d[i] = enc_c[i][2];
            end else if (sync_clr) begin
                r_d[i] = 1'b0;
            end
        end

        out_valid_d = out_valid_q;
        codeout_d   = codeout_q;
        lane_err_d  = lane_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            codeout_d   = code_c;
            lane_err_d  = err_c;
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end

        // An erroneous accept wins over a simultaneous clear.
        err_sticky_d = err_sticky_q;
        if (accept && any_err) begin
            err_sticky_d = 1'b1;
        end else if (sync_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // Register stream outputs, lane memory and sticky error.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            codeout_q    <= '0;
            lane_err_q   <= '0;
            err_sticky_q <= 1'b0;
            r_q          <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            codeout_q    <= codeout_d;
            lane_err_q   <= lane_err_d;
            err_sticky_q <= err_sticky_d;
            r_q          <= r_d;
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.codeout   = codeout_q;
    assign bus_io.lane_err  = lane_err_q;
    assign err_sticky       = err_sticky_q;

`ifdef TNS_MULTI_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of accepted beats carrying any lane error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_clr) begin
            err_cnt_d = (accept && any_err) ? 16'd1 : 16'd0;
        end else if (accept && any_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Register the error count.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tns_encoder_multi.sv
// Directed self-checking bench for tns_encoder_multi (default parameters).
module tb_tns_encoder_multi;

    logic clock;
    logic rst_n;
    logic sync_clr;
    logic err_sticky;
`ifdef TNS_MULTI_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_checks;
    int n_fail;

    tns_encoder_multi_if #(.LANES(4), .DW(3)) bus_if ();

    tns_encoder_multi #(
        .LANES (4),
        .DW    (3),
        .TNS_A (3),
        .TNS_B (2),
        .TNS_C (1)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .bus_io     (bus_if.slave),
        .err_sticky (err_sticky)
`ifdef TNS_MULTI_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one beat; lane symbols given as {l3,l2,l1,l0}, then sample 1 after the edge.
    task automatic beat(input logic vld, input logic clr, input logic [11:0] syms);
        bus_if.in_valid = vld;
        sync_clr        = clr;
        bus_if.datain   = syms;
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        sync_clr        = 1'b0;
    endtask

    logic [2:0] seq_in  [5];
    logic [2:0] seq_exp [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        sync_clr         = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.datain    = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("rst_codeout", {20'd0, bus_if.codeout}, 32'd0);
        check_eq("rst_lane_err", {28'd0, bus_if.lane_err}, 32'd0);
        check_eq("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Back-to-back lane0 sequence 3,5,3,0,6.
        seq_in  = '{3'd3, 3'd5, 3'd3, 3'd0, 3'd6};
        seq_exp = '{3'b011, 3'b110, 3'b100, 3'b000, 3'b111};
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.datain   = {9'd0, seq_in[i]};
            @(posedge clock);
            #1;
            check_eq("seq_code", {29'd0, bus_if.codeout[2:0]}, {29'd0, seq_exp[i]});
            check_eq("seq_valid", {31'd0, bus_if.out_valid}, 32'd1);
        end
        bus_if.in_valid = 1'b0;
        @(posedge clock);
        #1;
        check_eq("drain_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Stall: accept 5, then hold 3 while out_ready=0.
        beat(1'b1, 1'b0, 12'o0005);
        check_eq("stall_first", {29'd0, bus_if.codeout[2:0]}, 32'b110);
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.datain    = 12'o0003;
        #1;
        check_eq("stall_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_eq("stall_hold", {29'd0, bus_if.codeout[2:0]}, 32'b110);
            check_eq("stall_hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        beat(1'b1, 1'b0, 12'o0003);
        check_eq("after_stall", {29'd0, bus_if.codeout[2:0]}, 32'b100);

        // sync_clr with accept: r forced to 0, then stays 0.
        beat(1'b1, 1'b1, 12'o0003);
        check_eq("clr_accept", {29'd0, bus_if.codeout[2:0]}, 32'b011);
        beat(1'b1, 1'b0, 12'o0003);
        check_eq("clr_follow", {29'd0, bus_if.codeout[2:0]}, 32'b011);

        // Out-of-range on lane2 with lane2 memory set beforehand.
        beat(1'b1, 1'b0, 12'o0500);
        check_eq("oor_prep", {20'd0, bus_if.codeout}, 32'h180);
        beat(1'b1, 1'b0, 12'o5730);
        check_eq("oor_code", {20'd0, bus_if.codeout}, 32'hC18);
        check_eq("oor_lane_err", {28'd0, bus_if.lane_err}, 32'h4);
        check_eq("oor_sticky", {31'd0, err_sticky}, 32'd1);
        beat(1'b1, 1'b0, 12'o0300);
        check_eq("oor_r_kept", {20'd0, bus_if.codeout}, 32'h100);
        check_eq("oor_err_clear", {28'd0, bus_if.lane_err}, 32'h0);
        check_eq("oor_sticky_hold", {31'd0, err_sticky}, 32'd1);
        beat(1'b0, 1'b1, 12'o0000);
        check_eq("clr_sticky", {31'd0, err_sticky}, 32'd0);
        beat(1'b1, 1'b1, 12'o0700);
        check_eq("set_wins_sticky", {31'd0, err_sticky}, 32'd1);
        beat(1'b0, 1'b1, 12'o0000);
        check_eq("clr_sticky2", {31'd0, err_sticky}, 32'd0);

        // Async reset while holding a stalled, erroneous beat.
        beat(1'b1, 1'b0, 12'o0705);
        bus_if.out_ready = 1'b0;
        check_eq("pre_rst_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check_eq("pre_rst_sticky", {31'd0, err_sticky}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check_eq("arst_codeout", {20'd0, bus_if.codeout}, 32'd0);
        check_eq("arst_sticky", {31'd0, err_sticky}, 32'd0);
        check_eq("arst_lane_err", {28'd0, bus_if.lane_err}, 32'd0);
        #2;
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clock);
        #1;
        beat(1'b1, 1'b0, 12'o0003);
        check_eq("post_rst_code", {20'd0, bus_if.codeout}, 32'h003);

`ifdef TNS_MULTI_ERRCNT_EN
        beat(1'b0, 1'b1, 12'o0000);
        check_eq("cnt_zero", {16'd0, err_cnt}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            beat(1'b1, 1'b0, 12'o0700);
            check_eq("cnt_inc", {16'd0, err_cnt}, i);
        end
        beat(1'b0, 1'b1, 12'o0000);
        check_eq("cnt_clr", {16'd0, err_cnt}, 32'd0);
        beat(1'b1, 1'b1, 12'o0700);
        check_eq("cnt_clr_err", {16'd0, err_cnt}, 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.datain   = 12'o0700;
        repeat (65540) @(posedge clock);
        #1;
        check_eq("cnt_sat", {16'd0, err_cnt}, 32'hFFFF);
        @(posedge clock);
        #1;
        check_eq("cnt_sat_hold", {16'd0, err_cnt}, 32'hFFFF);
        bus_if.in_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
